// File: rtl/uart_periph_pkg.sv
// Shared definitions for the uart_fifo_periph UART peripheral: register
// offsets, FSM state encodings, STATUS/ERR bit positions and divisor helpers.
// Optional feature macro: UART_PARITY_EN (adds the PARITY state to both FSMs).
package uart_periph_pkg;

    // Register offsets relative to BaseAddress
    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DIVLO  = 3'd3;
    localparam logic [2:0] REG_DIVHI  = 3'd4;
    localparam logic [2:0] REG_ERR    = 3'd5;
    localparam int         NumRegs    = 6;

    // STATUS bit positions
    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_TX_EMPTY = 3;
    localparam int ST_TX_BUSY  = 4;
    localparam int ST_ANYERR   = 7;

    // ERR bit positions
    localparam int ERR_OVERRUN = 0;
    localparam int ERR_FRAMING = 1;
    localparam int ERR_TXOVF   = 2;
    localparam int ERR_PARITY  = 3;

    // Smallest bit time the engines can handle (needs a distinct mid-bit sample point)
    localparam logic [15:0] MinDivisor = 16'd4;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`endif

    // Divisor values below the minimum are replaced by the minimum
    function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
        return (value < MinDivisor) ? MinDivisor : value;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO used for both the TX and RX queues.
// dout_o always presents the head entry; a push into a full FIFO is accepted
// only when a pop happens in the same cycle, so simultaneous push/pop keeps the count.
// Optional feature macro: none (UART_PARITY_EN does not affect this module).
module uart_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [Width-1:0] din_i,
    input  logic             pop_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AW:0] FullCount = (AW + 1)'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (r_count == FullCount);
    assign empty_o   = (r_count == '0);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign dout_o    = r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART peripheral: six byte registers on an 8-bit bus, TX/RX
// FIFOs, runtime baud divisor, sticky write-1-to-clear error flags.
// Optional feature macro: UART_PARITY_EN (even parity bit between data and stop).
module uart_fifo_periph
    import uart_periph_pkg::*;
#(
    parameter int BaseAddress    = 0,
    parameter int TxDepth        = 16,
    parameter int RxDepth        = 16,
    parameter int DataBits       = 8,
    parameter int StopBits       = 1,
    parameter int DefaultDivisor = 434
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] address_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    input  logic        rd_wr_i,
    output logic        tx_o,
    input  logic        rx_i
);
    localparam logic [16:0] BaseAddr17 = 17'(BaseAddress);
    localparam logic [7:0]  DataMask   = 8'((16'd1 << DataBits) - 16'd1);

    // ---------------- bus decode ----------------
    logic [16:0] w_rel;
    logic        w_hit;
    logic [2:0]  w_reg;
    logic        w_wr;
    logic        w_rd;

    assign w_rel = {1'b0, address_i} - BaseAddr17;
    assign w_hit = (w_rel < 17'(NumRegs));
    assign w_reg = w_rel[2:0];
    assign w_wr  = rd_wr_i && w_hit;
    assign w_rd  = !rd_wr_i && w_hit;

    // ---------------- FIFOs ----------------
    logic                w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]          w_tx_dout;
    logic                w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [DataBits-1:0] w_rx_dout;
    logic [DataBits-1:0] r_rx_shift;

    assign w_tx_push = w_wr && (w_reg == REG_TXDATA);
    assign w_rx_pop  = w_rd && (w_reg == REG_RXDATA);

    uart_sync_fifo #(.Width(8), .Depth(TxDepth)) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_tx_push),
        .din_i   (data_i),
        .pop_i   (w_tx_pop),
        .dout_o  (w_tx_dout),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty)
    );

    uart_sync_fifo #(.Width(DataBits), .Depth(RxDepth)) u_rx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_rx_push),
        .din_i   (r_rx_shift),
        .pop_i   (w_rx_pop),
        .dout_o  (w_rx_dout),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty)
    );

    // ---------------- divisor register ----------------
    logic [15:0] r_div;

    // Divisor register; each byte write is clamped to the minimum bit time
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_div <= 16'(DefaultDivisor);
        end else if (w_wr && (w_reg == REG_DIVLO)) begin
            r_div <= clamp_divisor({r_div[15:8], data_i});
        end else if (w_wr && (w_reg == REG_DIVHI)) begin
            r_div <= clamp_divisor({data_i, r_div[7:0]});
        end
    end

    // ---------------- TX engine ----------------
    tx_state_t   r_tx_state, w_tx_state_next;
    logic [15:0] r_tx_cnt, w_tx_cnt_next;
    logic [15:0] r_tx_div, w_tx_div_next;
    logic [7:0]  r_tx_shift, w_tx_shift_next;
    logic [3:0]  r_tx_bitn, w_tx_bitn_next;
    logic        r_tx_par, w_tx_par_next;
    logic        r_tx_o, w_tx_o_next;
    logic        w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);
    assign tx_o         = r_tx_o;

    // TX next-state: bit timing, shifting and back-to-back frame loading
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_div_next   = r_tx_div;
        w_tx_shift_next = r_tx_shift;
        w_tx_bitn_next  = r_tx_bitn;
        w_tx_par_next   = r_tx_par;
        w_tx_o_next     = r_tx_o;
        w_tx_pop        = 1'b0;
        if (r_tx_state != TX_IDLE) begin
            w_tx_cnt_next = w_tx_bit_end ? 16'd0 : r_tx_cnt + 16'd1;
        end
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_o_next = 1'b1;
                w_tx_pop    = !w_tx_empty;
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_next = TX_DATA;
                    w_tx_bitn_next  = 4'd0;
                    w_tx_o_next     = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    if (r_tx_bitn == 4'(DataBits - 1)) begin
`ifdef UART_PARITY_EN
                        w_tx_state_next = TX_PARITY;
                        w_tx_o_next     = r_tx_par;
`else
                        w_tx_state_next = TX_STOP;
                        w_tx_bitn_next  = 4'd0;
                        w_tx_o_next     = 1'b1;
`endif
                    end else begin
                        w_tx_shift_next = r_tx_shift >> 1;
                        w_tx_bitn_next  = r_tx_bitn + 4'd1;
                        w_tx_o_next     = r_tx_shift[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (w_tx_bit_end) begin
                    w_tx_state_next = TX_STOP;
                    w_tx_bitn_next  = 4'd0;
                    w_tx_o_next     = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (r_tx_bitn == 4'(StopBits - 1)) begin
                        if (!w_tx_empty) begin
                            w_tx_pop = 1'b1;
                        end else begin
                            w_tx_state_next = TX_IDLE;
                            w_tx_o_next     = 1'b1;
                        end
                    end else begin
                        w_tx_bitn_next = r_tx_bitn + 4'd1;
                    end
                end
            end
            default: begin
                w_tx_state_next = TX_IDLE;
                w_tx_o_next     = 1'b1;
            end
        endcase
        // Starting a frame: take the head byte and capture the current divisor
        if (w_tx_pop) begin
            w_tx_state_next = TX_START;
            w_tx_cnt_next   = 16'd0;
            w_tx_div_next   = r_div;
            w_tx_shift_next = w_tx_dout;
            w_tx_par_next   = ^(w_tx_dout & DataMask);
            w_tx_o_next     = 1'b0;
        end
    end

    // TX state register; line output is registered and idles high
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_div   <= 16'(DefaultDivisor);
            r_tx_shift <= 8'd0;
            r_tx_bitn  <= 4'd0;
            r_tx_par   <= 1'b0;
            r_tx_o     <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_div   <= w_tx_div_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_bitn  <= w_tx_bitn_next;
            r_tx_par   <= w_tx_par_next;
            r_tx_o     <= w_tx_o_next;
        end
    end

    // ---------------- RX engine ----------------
    logic                r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t           r_rx_state, w_rx_state_next;
    logic [15:0]         r_rx_cnt, w_rx_cnt_next;
    logic [15:0]         r_rx_div, w_rx_div_next;
    logic [DataBits-1:0] w_rx_shift_next;
    logic [3:0]          r_rx_bitn, w_rx_bitn_next;
    logic                r_rx_par, w_rx_par_next;
    logic                w_rx_fall, w_rx_half, w_rx_bit_end;
    logic                w_set_overrun, w_set_framing, w_set_parity;

    assign w_rx_fall    = r_rx_prev && !r_rx_sync;
    assign w_rx_half    = (r_rx_cnt == {1'b0, r_rx_div[15:1]});
    assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);

    // Two-flop synchroniser plus edge-detect history for the serial input
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX next-state: mid-bit sampling, glitch rejection and error classification
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_div_next   = r_rx_div;
        w_rx_shift_next = r_rx_shift;
        w_rx_bitn_next  = r_rx_bitn;
        w_rx_par_next   = r_rx_par;
        w_rx_push       = 1'b0;
        w_set_overrun   = 1'b0;
        w_set_framing   = 1'b0;
        w_set_parity    = 1'b0;
        if ((r_rx_state != RX_IDLE) && (r_rx_state != RX_WAIT_HIGH)) begin
            w_rx_cnt_next = w_rx_bit_end ? 16'd0 : r_rx_cnt + 16'd1;
        end
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    // The detection cycle already counts as the first cycle of the start bit
                    w_rx_state_next = RX_START;
                    w_rx_cnt_next   = 16'd1;
                    w_rx_div_next   = r_div;
                end
            end
            RX_START: begin
                if (w_rx_half && r_rx_sync) begin
                    w_rx_state_next = RX_IDLE;
                end else if (w_rx_bit_end) begin
                    w_rx_state_next = RX_DATA;
                    w_rx_bitn_next  = 4'd0;
                end
            end
            RX_DATA: begin
                if (w_rx_half) begin
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[DataBits-1:1]};
                end
                if (w_rx_bit_end) begin
                    if (r_rx_bitn == 4'(DataBits - 1)) begin
`ifdef UART_PARITY_EN
                        w_rx_state_next = RX_PARITY;
`else
                        w_rx_state_next = RX_STOP;
`endif
                    end else begin
                        w_rx_bitn_next = r_rx_bitn + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (w_rx_half) begin
                    w_rx_par_next = r_rx_sync;
                end
                if (w_rx_bit_end) begin
                    w_rx_state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Decide at mid-stop so the next start edge is never missed
                if (w_rx_half) begin
                    if (!r_rx_sync) begin
                        w_set_framing   = 1'b1;
                        w_rx_state_next = RX_WAIT_HIGH;
                    end else begin
                        w_rx_state_next = RX_IDLE;
`ifdef UART_PARITY_EN
                        if ((^r_rx_shift) != r_rx_par) begin
                            w_set_parity = 1'b1;
                        end else
`endif
                        if (w_rx_full && !w_rx_pop) begin
                            w_set_overrun = 1'b1;
                        end else begin
                            w_rx_push = 1'b1;
                        end
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (r_rx_sync) begin
                    w_rx_state_next = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_next = RX_IDLE;
            end
        endcase
    end

    // RX state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= 16'(DefaultDivisor);
            r_rx_shift <= '0;
            r_rx_bitn  <= 4'd0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_div   <= w_rx_div_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_bitn  <= w_rx_bitn_next;
            r_rx_par   <= w_rx_par_next;
        end
    end

    // ---------------- error flags ----------------
    logic [3:0] r_err;
    logic [3:0] w_err_set;
    logic [3:0] w_err_clr;
    logic       w_set_txovf;

    assign w_set_txovf = w_tx_push && w_tx_full && !w_tx_pop;
    assign w_err_clr   = (w_wr && (w_reg == REG_ERR)) ? data_i[3:0] : 4'd0;

    always_comb begin
        w_err_set              = 4'd0;
        w_err_set[ERR_OVERRUN] = w_set_overrun;
        w_err_set[ERR_FRAMING] = w_set_framing;
        w_err_set[ERR_TXOVF]   = w_set_txovf;
        w_err_set[ERR_PARITY]  = w_set_parity;
    end

    // Sticky flags: a set event in the same cycle wins over a clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err <= 4'd0;
        end else begin
            r_err <= (r_err & ~w_err_clr) | w_err_set;
        end
    end

    // ---------------- read path ----------------
    logic [7:0] w_status;
    logic [7:0] w_rd_data;
    logic [7:0] r_data_o;

    always_comb begin
        w_status              = 8'd0;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_TX_BUSY]  = (r_tx_state != TX_IDLE);
        w_status[ST_ANYERR]   = |r_err;
    end

    // Read data mux; unmapped addresses and an empty RX FIFO read as zero
    always_comb begin
        w_rd_data = 8'd0;
        if (w_hit) begin
            case (w_reg)
                REG_RXDATA: w_rd_data = w_rx_empty ? 8'd0 : 8'(w_rx_dout);
                REG_STATUS: w_rd_data = w_status;
                REG_DIVLO:  w_rd_data = r_div[7:0];
                REG_DIVHI:  w_rd_data = r_div[15:8];
                REG_ERR:    w_rd_data = {4'd0, r_err};
                default:    w_rd_data = 8'd0;
            endcase
        end
    end

    // Registered read data; held on write cycles
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data_o <= 8'd0;
        end else if (!rd_wr_i) begin
            r_data_o <= w_rd_data;
        end
    end

    assign data_o = r_data_o;

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Self-checking bench for uart_fifo_periph: randomized bytes checked against
// queue-based expectations, a line-level TX decoder and an RX frame driver.
// Optional feature macro: UART_PARITY_EN (bench expects a parity bit when defined).
module tb_uart_fifo_periph;

    localparam logic [15:0] A_TX = 16'd0, A_RX = 16'd1, A_ST = 16'd2;
    localparam logic [15:0] A_DL = 16'd3, A_DH = 16'd4, A_ER = 16'd5;
    localparam logic [15:0] A_IDLE = 16'h0100;
    localparam int TXD = 16, RXD = 16;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = A_IDLE;
    logic [7:0]  din = 8'd0;
    logic [7:0]  dout;
    logic        rd_wr = 1'b0;
    logic        tx;
    logic        rx;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    int          cyc = 0;
    int          cur_div = 434;
    int          total = 0;
    int          bad = 0;

    logic [7:0] mon_q[$];
    int         mon_start[$];
    logic       mon_stop[$];
    logic       mon_par[$];

    assign rx = loop ? tx : rx_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_fifo_periph dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .address_i (addr),
        .data_i    (din),
        .data_o    (dout),
        .rd_wr_i   (rd_wr),
        .tx_o      (tx),
        .rx_i      (rx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int d);
        return d * (1 + 8 + PB + 1);
    endfunction

    function automatic logic [7:0] exp_status(input int rxn, input int txn, input bit busy, input bit anyerr);
        return {anyerr, 2'b00, busy, (txn == 0), (txn == TXD), (rxn == RXD), (rxn == 0)};
    endfunction

    // All bus tasks are entered at a falling edge and return at one
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        rd_wr = 1'b1; addr = a; din = d;
        @(negedge clk);
        rd_wr = 1'b0; addr = A_IDLE;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        rd_wr = 1'b0; addr = a;
        @(negedge clk);
        d = dout;
        addr = A_IDLE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        rx_drv = 1'b0;
        idle(cur_div);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            idle(cur_div);
        end
        if (PB != 0) begin
            rx_drv = (^b) ^ bad_par;
            idle(cur_div);
        end
        rx_drv = !bad_stop;
        idle(cur_div);
        rx_drv = 1'b1;
    endtask

    task automatic clear_mon();
        mon_q.delete(); mon_start.delete(); mon_stop.delete(); mon_par.delete();
    endtask

    // Line-level decoder of tx: samples every bit in its middle
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] b;
        logic       p;
        int         d;
        int         st;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx && !rst) begin
                st = cyc;
                d  = cur_div;
                repeat (d / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx;
                end
                p = 1'b0;
                if (PB != 0) begin
                    repeat (d) @(negedge clk);
                    p = tx;
                end
                repeat (d) @(negedge clk);
                mon_q.push_back(b);
                mon_start.push_back(st);
                mon_stop.push_back(tx);
                mon_par.push_back(p);
            end
            prev = tx;
        end
    end

    initial begin : main
        logic [7:0] r;
        logic [7:0] exp_q[$];
        logic [7:0] b1, b2;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_dout", dout, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset values, read hold on writes, divisor clamp, unmapped read
        bus_read(A_DL, r); chk("rst_divlo", r, 8'hB2);
        bus_read(A_DH, r); chk("rst_divhi", r, 8'h01);
        bus_read(A_ER, r); chk("rst_err", r, 8'h00);
        bus_read(A_ST, r); chk("rst_status", r, exp_status(0, 0, 0, 0));
        bus_write(A_DH, 8'h00);
        chk("hold_on_write", dout, exp_status(0, 0, 0, 0));
        bus_write(A_DL, 8'h02);
        bus_read(A_DL, r); chk("div_clamp", r, 8'h04);
        bus_read(16'h0006, r); chk("unmapped", r, 8'h00);
        bus_write(A_DL, 8'h08);
        cur_div = 8;

        // Loopback: ordered delivery, frame length, no inter-frame gap
        loop = 1'b1;
        clear_mon();
        exp_q = '{8'hA5, 8'h3C, 8'h07, 8'($urandom), 8'($urandom), 8'($urandom)};
        foreach (exp_q[i]) bus_write(A_TX, exp_q[i]);
        idle(exp_q.size() * frame_len(8) + 40);
        chk("lb_count", mon_q.size(), exp_q.size());
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("lb_txbyte%0d", i), mon_q[i], exp_q[i]);
            chk($sformatf("lb_stop%0d", i), mon_stop[i], 1);
`ifdef UART_PARITY_EN
            chk($sformatf("lb_parity%0d", i), mon_par[i], ^exp_q[i]);
`endif
            if (i > 0) chk($sformatf("lb_gap%0d", i), mon_start[i] - mon_start[i-1], frame_len(8));
        end
        bus_read(A_ST, r); chk("lb_status", r, exp_status(exp_q.size(), 0, 0, 0));
        foreach (exp_q[i]) begin
            bus_read(A_RX, r); chk($sformatf("lb_rx%0d", i), r, exp_q[i]);
        end
        bus_read(A_RX, r); chk("rx_empty_read", r, 8'h00);
        bus_read(A_ST, r); chk("lb_status_empty", r, exp_status(0, 0, 0, 0));
        loop = 1'b0;

        // TX overflow: one byte leaves for the line, TXD fit, the rest is dropped
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < TXD + 2; i++) begin
            exp_q.push_back(8'($urandom));
            bus_write(A_TX, exp_q[i]);
        end
        bus_read(A_ST, r); chk("txovf_status", r, exp_status(0, TXD, 1, 1));
        bus_read(A_ER, r); chk("txovf_err", r, 8'h04);
        bus_write(A_ER, 8'h04);
        bus_read(A_ER, r); chk("txovf_clear", r, 8'h00);
        idle((TXD + 1) * frame_len(8) + 40);
        chk("txovf_sent", mon_q.size(), TXD + 1);
        for (int i = 0; i < mon_q.size() && i < TXD + 1; i++)
            chk($sformatf("txovf_byte%0d", i), mon_q[i], exp_q[i]);

        // RX overrun: RXD+1 frames without reading
        exp_q.delete();
        for (int i = 0; i < RXD + 1; i++) begin
            exp_q.push_back(8'($urandom));
            send_frame(exp_q[i], 0, 0);
        end
        idle(2 * cur_div);
        bus_read(A_ST, r); chk("ovr_status", r, exp_status(RXD, 0, 0, 1));
        bus_read(A_ER, r); chk("ovr_err", r, 8'h01);
        for (int i = 0; i < RXD; i++) begin
            bus_read(A_RX, r); chk($sformatf("ovr_rx%0d", i), r, exp_q[i]);
        end
        bus_read(A_ST, r); chk("ovr_status_after", r, exp_status(0, 0, 0, 1));
        bus_write(A_ER, 8'h01);
        bus_read(A_ER, r); chk("ovr_clear", r, 8'h00);

        // Framing error, then a short glitch
        send_frame(8'h55, 1, 0);
        idle(2 * cur_div);
        bus_read(A_ER, r); chk("frm_err", r, 8'h02);
        bus_read(A_ST, r); chk("frm_status", r, exp_status(0, 0, 0, 1));
        bus_write(A_ER, 8'h02);
        rx_drv = 1'b0;
        idle(2);
        rx_drv = 1'b1;
        idle(3 * cur_div);
        bus_read(A_ER, r); chk("glitch_err", r, 8'h00);
        bus_read(A_ST, r); chk("glitch_status", r, exp_status(0, 0, 0, 0));

`ifdef UART_PARITY_EN
        send_frame(8'($urandom), 0, 1);
        idle(2 * cur_div);
        bus_read(A_ER, r); chk("par_err", r, 8'h08);
        bus_read(A_ST, r); chk("par_status", r, exp_status(0, 0, 0, 1));
        bus_write(A_ER, 8'h08);
`endif

        // Divisor change mid-frame applies from the next frame
        clear_mon();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(A_TX, b1);
        idle(20);
        bus_write(A_DL, 8'h10);
        cur_div = 16;
        bus_write(A_TX, b2);
        idle(frame_len(8) + frame_len(16) + 40);
        chk("divchg_count", mon_q.size(), 2);
        if (mon_q.size() == 2) begin
            chk("divchg_byte0", mon_q[0], b1);
            chk("divchg_byte1", mon_q[1], b2);
            chk("divchg_oldtime", mon_start[1] - mon_start[0], frame_len(8));
            chk("divchg_stop1", mon_stop[1], 1);
        end

        // Reset mid-frame with a second byte still queued
        bus_write(A_TX, 8'h00);
        bus_write(A_TX, 8'h5A);
        idle(30);
        chk("pre_rst_tx", tx, 0);
        #1 rst = 1'b1;
        #1 chk("rst_async_tx", tx, 1);
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_dout", dout, 0);
        bus_read(A_DL, r); chk("rst2_divlo", r, 8'hB2);
        bus_read(A_DH, r); chk("rst2_divhi", r, 8'h01);
        bus_read(A_ST, r); chk("rst2_status", r, exp_status(0, 0, 0, 0));
        bus_read(A_ER, r); chk("rst2_err", r, 8'h00);
        idle(50);
        chk("rst2_tx_idle", tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
